// File: rtl/spike_aer_pkg.sv
// Shared constants, event record and small combinational helpers for the AER encoder.
package spike_aer_pkg;

  localparam int unsigned NUM_NEURONS = 8;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned TS_W        = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } aer_event_t;

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (v[i] && !found) begin
        lowest_set = ADDR_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_NEURONS-1:0] v);
    popcount = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      popcount = popcount + {3'b000, v[i]};
    end
  endfunction

endpackage

// File: rtl/spike_aer_encoder_fifo.sv
// Synchronous event FIFO with registered storage; head reads as zero while empty.
module aer_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      if (i_push && !i_pop)      r_level <= r_level + 1'b1;
      else if (i_pop && !i_push) r_level <= r_level - 1'b1;
    end
  end

  // When full, push+pop writes the slot being vacated; the head has already moved on.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  assign o_head  = (r_level != '0) ? r_mem[r_rd] : '0;
  assign o_level = r_level;

endmodule

// File: rtl/spike_aer_encoder.sv
// Converts a per-timestep spike vector into a stream of {neuron, timestamp} AER events.
module spike_aer_encoder
  import spike_aer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = TS_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_NEURONS-1:0]      spike,
  input  logic                        spike_valid,
  output logic                        aer_valid,
  input  logic                        aer_ready,
  output logic [ADDR_W-1:0]           aer_addr,
  output logic [TS_WIDTH-1:0]         aer_ts,
  output logic [7:0]                  drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_NEURONS-1:0]     r_pend;
  logic [TS_WIDTH-1:0]        r_ts;
  logic [7:0]                 r_drop;

  logic [NUM_NEURONS-1:0]     w_clr;
  logic [NUM_NEURONS-1:0]     w_in;
  logic [NUM_NEURONS-1:0]     w_drop;
  logic [ADDR_W-1:0]          w_k;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_full;
  logic [8:0]                 w_drop_sum;
  logic [ADDR_W+TS_WIDTH-1:0] w_din;
  logic [ADDR_W+TS_WIDTH-1:0] w_head;
  logic [LW-1:0]              w_level;

  assign w_full  = (w_level == LW'(FIFO_DEPTH));
  assign w_pop   = aer_valid & aer_ready;
  assign w_push  = (r_pend != '0) && (!w_full || w_pop);
  assign w_k     = lowest_set(r_pend);
  assign w_clr   = w_push ? (NUM_NEURONS'(1) << w_k) : '0;
  assign w_in    = spike_valid ? spike : '0;
  // A bit pushed this edge frees its slot, so a coincident spike on it is not a loss.
  assign w_drop  = w_in & r_pend & ~w_clr;
  assign w_drop_sum = {1'b0, r_drop} + 9'(popcount(w_drop));
  assign w_din   = {w_k, r_ts};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_ts   <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_in;
      if (spike_valid) r_ts <= r_ts + 1'b1;
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  aer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + TS_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_level (w_level)
  );

  assign aer_valid            = (w_level != '0);
  assign {aer_addr, aer_ts}   = w_head;
  assign drop_count           = r_drop;
  assign fifo_level           = w_level;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: queue-based event model plus literal checkpoints.
module tb_spike_aer_encoder;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] spike;
  logic       spike_valid;
  logic       aer_valid;
  logic       aer_ready;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts;
  logic [7:0] drop_count;
  logic [3:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int addr; int ts; } ev_t;
  ev_t        mq[$];
  logic [7:0] m_pend;
  int         m_ts;
  int         m_drop;

  spike_aer_encoder #(
    .FIFO_DEPTH (DEPTH),
    .TS_WIDTH   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spike       (spike),
    .spike_valid (spike_valid),
    .aer_valid   (aer_valid),
    .aer_ready   (aer_ready),
    .aer_addr    (aer_addr),
    .aer_ts      (aer_ts),
    .drop_count  (drop_count),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend = '0;
    m_ts   = 0;
    m_drop = 0;
  endtask

  // One timestep of the encoder's rules, evaluated on the pre-edge state.
  task automatic model_step();
    bit         pop;
    bit         push;
    int         k;
    logic [7:0] np;
    pop  = (mq.size() != 0) && aer_ready;
    push = (m_pend != 0) && ((mq.size() < DEPTH) || pop);
    k = -1;
    for (int i = 0; i < 8; i++) if (m_pend[i] && k < 0) k = i;
    np = m_pend;
    if (push) np[k] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (spike_valid && spike[i]) begin
        if (np[i]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        np[i] = 1'b1;
      end
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back('{addr: k, ts: m_ts});
    if (spike_valid) m_ts = (m_ts + 1) % 256;
    m_pend = np;
  endtask

  always @(posedge clk) begin
    if (rst) model_clear();
    else     model_step();
  end

  always @(negedge clk) begin
    check("valid", aer_valid, mq.size() != 0);
    check("level", fifo_level, mq.size());
    check("drop",  drop_count, m_drop);
    if (mq.size() != 0) begin
      check("addr", aer_addr, mq[0].addr);
      check("ts",   aer_ts,   mq[0].ts);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    spike = '0;
    spike_valid = 1'b0;
    aer_ready = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    spike = '0;
    spike_valid = 1'b0;
    aer_ready = 1'b0;
    model_clear();
    #1;
    check("rst_valid", aer_valid, 0);
    check("rst_addr",  aer_addr,  0);
    check("rst_ts",    aer_ts,    0);
    check("rst_level", fifo_level, 0);
    check("rst_drop",  drop_count, 0);
    cyc(2);
    rst = 1'b0;

    // two-bit spike, consumer always ready
    aer_ready = 1'b1;
    spike = 8'b0000_0101;
    spike_valid = 1'b1;
    cyc(1);
    spike_valid = 1'b0;
    spike = '0;
    cyc(1);
    check("basic_v0", aer_valid, 1);
    check("basic_a0", aer_addr, 0);
    check("basic_t0", aer_ts, 1);
    cyc(1);
    check("basic_a1", aer_addr, 2);
    check("basic_t1", aer_ts, 1);
    cyc(1);
    check("basic_empty", aer_valid, 0);
    check("basic_drop", drop_count, 0);

    // fill to full with consumer stalled, then drain in order
    do_reset();
    spike = 8'hFF;
    spike_valid = 1'b1;
    cyc(1);
    spike_valid = 1'b0;
    spike = '0;
    cyc(7);
    check("fill_lvl7", fifo_level, 7);
    cyc(1);
    check("fill_lvl8", fifo_level, 8);
    check("fill_addr", aer_addr, 0);
    check("fill_ts",   aer_ts, 1);
    cyc(2);
    check("fill_hold_lvl",  fifo_level, 8);
    check("fill_hold_addr", aer_addr, 0);
    aer_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_addr", aer_addr, i);
      cyc(1);
    end
    check("drain_empty", aer_valid, 0);

    // repeated spike on a pending bit while full
    do_reset();
    spike = 8'hFF;
    spike_valid = 1'b1;
    cyc(1);
    spike_valid = 1'b0;
    spike = '0;
    cyc(8);
    check("full_lvl", fifo_level, 8);
    spike = 8'h08;
    spike_valid = 1'b1;
    cyc(1);
    check("full_drop0", drop_count, 0);
    cyc(1);
    check("full_drop1", drop_count, 1);
    check("full_lvl_kept", fifo_level, 8);
    spike_valid = 1'b0;
    spike = '0;
    cyc(1);
    check("full_addr_kept", aer_addr, 0);
    aer_ready = 1'b1;
    cyc(8);
    check("pend3_addr", aer_addr, 3);
    check("pend3_ts",   aer_ts, 3);
    check("pend3_lvl",  fifo_level, 1);
    cyc(1);
    check("pend3_empty", aer_valid, 0);

    // timestamp wrap
    do_reset();
    spike_valid = 1'b1;
    cyc(255);
    spike = 8'h01;
    cyc(1);
    spike_valid = 1'b0;
    spike = '0;
    cyc(1);
    check("wrap_valid", aer_valid, 1);
    check("wrap_addr",  aer_addr, 0);
    check("wrap_ts",    aer_ts, 0);
    aer_ready = 1'b1;
    cyc(1);
    check("wrap_empty", aer_valid, 0);

    // drop counter saturation
    do_reset();
    spike = 8'hFF;
    spike_valid = 1'b1;
    cyc(1);
    spike_valid = 1'b0;
    cyc(8);
    spike_valid = 1'b1;
    cyc(1);
    check("sat_d0", drop_count, 0);
    cyc(1);
    check("sat_d8", drop_count, 8);
    cyc(30);
    check("sat_d248", drop_count, 248);
    cyc(1);
    check("sat_d255", drop_count, 255);
    cyc(10);
    check("sat_hold", drop_count, 255);
    spike_valid = 1'b0;
    spike = '0;

    // coincident push/spike, a drop, then reset mid-operation
    do_reset();
    spike = 8'hFF;
    spike_valid = 1'b1;
    cyc(1);
    spike = 8'h01;
    cyc(1);
    check("coinc_nodrop", drop_count, 0);
    spike = 8'h80;
    cyc(1);
    check("coinc_drop1", drop_count, 1);
    spike_valid = 1'b0;
    spike = '0;
    cyc(3);
    check("pre_rst_lvl", fifo_level, 5);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("async_valid", aer_valid, 0);
    check("async_level", fifo_level, 0);
    check("async_drop",  drop_count, 0);
    check("async_addr",  aer_addr, 0);
    check("async_ts",    aer_ts, 0);
    cyc(1);
    rst = 1'b0;
    aer_ready = 1'b1;
    cyc(10);
    check("post_rst_valid", aer_valid, 0);
    check("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 FIFO_DEPTH, 8, event FIFO depth; power of two, 2..64.
REQ-002 TS_WIDTH, 8, timestamp width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset (asserts immediately, releases synchronously to clk).
REQ-005 spike  input  8  per-neuron spike vector from the time-multiplexed LIF array; bit i = neuron i fired.
REQ-006 spike_valid  input  1  spike vector is valid this cycle; also the timestep tick.
REQ-007 aer_valid  output  1  an event is presented on aer_addr/aer_ts.
REQ-008 aer_ready  input  1  consumer accepts the event.
REQ-009 aer_addr  output  3  neuron index of the head event.
REQ-010 aer_ts  output  TS_WIDTH  timestamp of the head event.
REQ-011 drop_count  output  8  saturating count of lost spikes.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Pending register pend[7:0]: on each edge with spike_valid=1, pend |= spike; spike ignored when spike_valid=0.
REQ-014 Timestamp counter ts increments by 1 on each edge with spike_valid=1; wraps 2^TS_WIDTH-1 -> 0.
REQ-015 Push condition: pend != 0 and (fifo_level < FIFO_DEPTH or pop this cycle).
REQ-016 On push: lowest set index k of pend is written as {addr=k, ts=current ts register value}; pend[k] cleared at same edge.
REQ-017 At most one push and one pop per cycle; simultaneous push+pop leaves fifo_level unchanged, including when full.
REQ-018 Pop occurs when aer_valid=1 and aer_ready=1; aer_valid = (fifo_level != 0); aer_addr/aer_ts driven from registered FIFO head, stable while aer_valid=1 and aer_ready=0.
REQ-019 Minimum latency: spike sampled at edge N -> event visible on aer outputs after edge N+1.
REQ-020 Drop: spike[i]=1 with spike_valid=1 while pend[i]=1 and bit i not pushed this cycle -> drop_count += 1 per such bit (multiple bits same cycle add their count); pend[i] stays 1.
REQ-021 Same-cycle push of bit i and new spike[i]: pend[i] remains 1, no drop counted.
REQ-022 drop_count saturates at 255; never wraps.
REQ-023 FIFO full with no pop: no push, pend retained; new spikes merge per REQ-013/020.
REQ-024 aer_ready with aer_valid=0 has no effect.

Reset
REQ-025 rst=1 clears pend, ts, FIFO pointers, fifo_level, drop_count; aer_valid=0, aer_addr=0, aer_ts=0 while in reset.
REQ-026 Reset mid-operation discards all pending and queued events; no event emitted from pre-reset state after release.
REQ-027 First edge after rst deassertion behaves as a normal operating cycle.

Structure
REQ-028 Package spike_aer_pkg holds NUM_NEURONS=8, ADDR_W=3, and the event record type {addr, ts}.
REQ-029 FIFO is a separate sub-module aer_fifo (synchronous, registered head, push/pop/level ports); priority encoder and drop logic remain in spike_aer_encoder.

Verification
REQ-030 Reset, then spike=8'b0000_0101 with spike_valid=1 for one cycle, aer_ready=1 -> events (addr 0, ts 1) then (addr 2, ts 1) on consecutive cycles; drop_count=0.
REQ-031 aer_ready=0, spike=8'hFF for one valid cycle, FIFO_DEPTH=8 -> fifo_level reaches 8 after 8 pushes, aer_addr=0 held stable; release ready -> addrs 0..7 in order.
REQ-032 aer_ready=0, FIFO full, spike[3]=1 on two consecutive valid cycles -> pend[3] set once, drop_count=1; no change to FIFO.
REQ-033 ts=255, spike_valid pulse -> ts wraps to 0; next event carries ts 0.
REQ-034 Force 300 drop events -> drop_count=255, stays 255.
REQ-035 rst pulse while fifo_level=5 and pend!=0 -> aer_valid=0 immediately, fifo_level=0, drop_count=0, no stale events after release.
